// File: rtl/fft_frame_loader_if.sv
// ============================================================================
//  Module      : fft_frame_loader_if
//  Description : Sample-in / frame-out bundle for the FFT frame loader.
//                master = sample source and frame consumer, slave = loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fft_frame_loader_if #(
  parameter int FCNT_W = 16
);
  logic [11:0]       sample_in;
  logic              sample_valid;
  logic              flush;
  logic [11:0]       x_0;
  logic [11:0]       x_1;
  logic [11:0]       x_2;
  logic [11:0]       x_3;
  logic [11:0]       x_4;
  logic [11:0]       x_5;
  logic [11:0]       x_6;
  logic [11:0]       x_7;
  logic              frame_valid;
  logic              filling;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output sample_in, sample_valid, flush,
    input  x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7,
    input  frame_valid, filling, frame_cnt
  );

  modport slave (
    input  sample_in, sample_valid, flush,
    output x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7,
    output frame_valid, filling, frame_cnt
  );
endinterface

`default_nettype wire

// File: rtl/fft_frame_loader.sv
// ============================================================================
//  Module      : fft_frame_loader
//  Description : Sliding 8-sample window feeding an 8-point FFT. Converts
//                offset-binary codes to two's complement and snapshots the
//                window onto x_0..x_7 every HOP accepted samples.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_frame_loader #(
  parameter int HOP        = 4,
  parameter bit OFFSET_BIN = 1'b1,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_frame_loader_if.slave bus
);

  localparam logic [0:0] c_ST_FILL   = 1'b0;
  localparam logic [0:0] c_ST_RUN    = 1'b1;
  localparam logic [2:0] c_FILL_LAST = 3'd7;
  localparam logic [2:0] c_HOP_LAST  = 3'(HOP - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [2:0]        r_fill_cnt;
  logic [2:0]        r_hop_cnt;
  logic [11:0]       r_win [8];
  logic [11:0]       w_nw  [8];
  logic [11:0]       r_x   [8];
  logic              r_frame_valid;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic [11:0]       w_conv;
  logic              w_accept;
  logic              w_snap;

  // A flush drops any sample presented alongside it.
  assign w_accept = bus.sample_valid & ~bus.flush;

  // Offset binary to two's complement is just an MSB flip.
  assign w_conv = OFFSET_BIN ? {~bus.sample_in[11], bus.sample_in[10:0]} : bus.sample_in;

  // Window as it will look after this edge's shift; this is what a snapshot copies.
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      w_nw[k] = r_win[k+1];
    end
    w_nw[7] = w_conv;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_FILL;
    else        r_state <= w_state_nxt;
  end

  // Next state: leave FILL on the 8th accepted sample, return on flush.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = c_ST_FILL;
    end else if (r_state == c_ST_FILL && w_accept && r_fill_cnt == c_FILL_LAST) begin
      w_state_nxt = c_ST_RUN;
    end
  end

  // Snapshot decode: window just became full, or the hop count is complete.
  always_comb begin
    w_snap = 1'b0;
    case (r_state)
      c_ST_FILL: w_snap = w_accept && (r_fill_cnt == c_FILL_LAST);
      c_ST_RUN:  w_snap = w_accept && (r_hop_cnt == c_HOP_LAST);
      default:   w_snap = 1'b0;
    endcase
  end

  // Fill and hop counters; hop_cnt is held at 0 throughout FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= 3'd0;
      r_hop_cnt  <= 3'd0;
    end else if (bus.flush) begin
      r_fill_cnt <= 3'd0;
      r_hop_cnt  <= 3'd0;
    end else if (w_accept) begin
      if (r_state == c_ST_FILL) begin
        r_fill_cnt <= r_fill_cnt + 3'd1;
      end else begin
        r_hop_cnt <= w_snap ? 3'd0 : r_hop_cnt + 3'd1;
      end
    end
  end

  // Sliding window shift register, oldest sample at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) r_win[k] <= 12'd0;
    end else if (bus.flush) begin
      for (int k = 0; k < 8; k++) r_win[k] <= 12'd0;
    end else if (w_accept) begin
      for (int k = 0; k < 8; k++) r_win[k] <= w_nw[k];
    end
  end

  // Output snapshot, frame strobe and frame counter; x_* survive a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) r_x[k] <= 12'd0;
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_valid <= w_snap;
      if (w_snap) begin
        for (int k = 0; k < 8; k++) r_x[k] <= w_nw[k];
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
    end
  end

  assign bus.x_0         = r_x[0];
  assign bus.x_1         = r_x[1];
  assign bus.x_2         = r_x[2];
  assign bus.x_3         = r_x[3];
  assign bus.x_4         = r_x[4];
  assign bus.x_5         = r_x[5];
  assign bus.x_6         = r_x[6];
  assign bus.x_7         = r_x[7];
  assign bus.frame_valid = r_frame_valid;
  assign bus.filling     = (r_state == c_ST_FILL);
  assign bus.frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_loader.sv
// ============================================================================
//  Module      : tb_fft_frame_loader
//  Description : Self-checking bench for fft_frame_loader. Three instances
//                (HOP=4/16-bit count, HOP=1/4-bit count, HOP=3 signed input)
//                share one stimulus stream and one sample-history model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_frame_loader;

  localparam int NI = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] s_in = 12'd0;
  logic        s_v  = 1'b0;
  logic        s_f  = 1'b0;

  fft_frame_loader_if #(.FCNT_W(16)) if_a ();
  fft_frame_loader_if #(.FCNT_W(4))  if_b ();
  fft_frame_loader_if #(.FCNT_W(8))  if_c ();

  assign if_a.sample_in = s_in;  assign if_a.sample_valid = s_v;  assign if_a.flush = s_f;
  assign if_b.sample_in = s_in;  assign if_b.sample_valid = s_v;  assign if_b.flush = s_f;
  assign if_c.sample_in = s_in;  assign if_c.sample_valid = s_v;  assign if_c.flush = s_f;

  fft_frame_loader #(.HOP(4), .OFFSET_BIN(1'b1), .FCNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  fft_frame_loader #(.HOP(1), .OFFSET_BIN(1'b1), .FCNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  fft_frame_loader #(.HOP(3), .OFFSET_BIN(1'b0), .FCNT_W(8))  dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // ---------------- reference model ----------------
  int          hop_of  [NI];
  bit          obin_of [NI];
  int          mod_of  [NI];
  logic [11:0] hist [$];          // raw samples accepted since last flush/reset (last 8)
  int          n_acc;             // samples accepted since last flush/reset
  bit          exp_fv  [NI];
  int          exp_cnt [NI];
  logic [11:0] exp_x   [NI][8];

  int n_tests = 0;
  int n_fail  = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  function automatic logic [11:0] conv(logic [11:0] s, bit ob);
    return ob ? 12'(s + 12'h800) : s;
  endfunction

  task automatic model_reset();
    hist.delete();
    n_acc = 0;
    for (int i = 0; i < NI; i++) begin
      exp_fv[i]  = 1'b0;
      exp_cnt[i] = 0;
      for (int k = 0; k < 8; k++) exp_x[i][k] = 12'd0;
    end
  endtask

  task automatic model_clock(logic [11:0] s, logic v, logic f);
    for (int i = 0; i < NI; i++) exp_fv[i] = 1'b0;
    if (f) begin
      hist.delete();
      n_acc = 0;
    end else if (v) begin
      hist.push_back(s);
      if (hist.size() > 8) void'(hist.pop_front());
      n_acc++;
      for (int i = 0; i < NI; i++) begin
        if (n_acc == 8 || (n_acc > 8 && (n_acc - 8) % hop_of[i] == 0)) begin
          exp_fv[i]  = 1'b1;
          exp_cnt[i] = (exp_cnt[i] + 1) % mod_of[i];
          for (int k = 0; k < 8; k++) exp_x[i][k] = conv(hist[k], obin_of[i]);
        end
      end
    end
  endtask

  // ---------------- DUT readback ----------------
  function automatic logic [11:0] act_x(int i, int k);
    logic [11:0] v [8];
    if (i == 0)      v = '{if_a.x_0, if_a.x_1, if_a.x_2, if_a.x_3, if_a.x_4, if_a.x_5, if_a.x_6, if_a.x_7};
    else if (i == 1) v = '{if_b.x_0, if_b.x_1, if_b.x_2, if_b.x_3, if_b.x_4, if_b.x_5, if_b.x_6, if_b.x_7};
    else             v = '{if_c.x_0, if_c.x_1, if_c.x_2, if_c.x_3, if_c.x_4, if_c.x_5, if_c.x_6, if_c.x_7};
    return v[k];
  endfunction

  function automatic logic [31:0] act_cnt(int i);
    if (i == 0) return 32'(if_a.frame_cnt);
    if (i == 1) return 32'(if_b.frame_cnt);
    return 32'(if_c.frame_cnt);
  endfunction

  function automatic logic act_fv(int i);
    if (i == 0) return if_a.frame_valid;
    if (i == 1) return if_b.frame_valid;
    return if_c.frame_valid;
  endfunction

  function automatic logic act_fill(int i);
    if (i == 0) return if_a.filling;
    if (i == 1) return if_b.filling;
    return if_c.filling;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s dut%0d frame_valid", tag, i), 32'(act_fv(i)), 32'(exp_fv[i]));
      chk($sformatf("%s dut%0d frame_cnt", tag, i), act_cnt(i), 32'(exp_cnt[i]));
      chk($sformatf("%s dut%0d filling", tag, i), 32'(act_fill(i)), 32'(n_acc < 8));
      for (int k = 0; k < 8; k++)
        chk($sformatf("%s dut%0d x_%0d", tag, i, k), 32'(act_x(i, k)), 32'(exp_x[i][k]));
    end
  endtask

  // One clock of stimulus; inputs change 1 time unit after the active edge.
  task automatic step(logic [11:0] s, logic v, logic f, string tag);
    s_in = s;
    s_v  = v;
    s_f  = f;
    @(posedge clk);
    model_clock(s, v, f);
    #1;
    check_all(tag);
    if (if_a.frame_valid === 1'b1) pulses_a++;
    if (if_b.frame_valid === 1'b1) pulses_b++;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic apply_reset(string tag);
    s_in  = 12'd0;
    s_v   = 1'b0;
    s_f   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, " async"});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all({tag, " held"});
  endtask

  typedef struct {
    logic [11:0] s;
    logic        v;
    logic        f;
    logic        fv;
    int          cnt;
    logic        fill;
    logic [11:0] x0;
    logic [11:0] x7;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int p0;
    logic [11:0] smp;
    int r;

    hop_of  = '{4, 1, 3};
    obin_of = '{1'b1, 1'b1, 1'b0};
    mod_of  = '{65536, 16, 256};

    // Hand-derived expectations for the HOP=4 instance: 0x800..0x80B back-to-back.
    for (int j = 0; j < 7; j++)
      tbl[j] = '{12'(12'h800 + j), 1'b1, 1'b0, 1'b0, 0, 1'b1, 12'h000, 12'h000};
    tbl[7]  = '{12'h807, 1'b1, 1'b0, 1'b1, 1, 1'b0, 12'h000, 12'h007};
    tbl[8]  = '{12'h000, 1'b0, 1'b0, 1'b0, 1, 1'b0, 12'h000, 12'h007};
    tbl[9]  = '{12'h808, 1'b1, 1'b0, 1'b0, 1, 1'b0, 12'h000, 12'h007};
    tbl[10] = '{12'h809, 1'b1, 1'b0, 1'b0, 1, 1'b0, 12'h000, 12'h007};
    tbl[11] = '{12'h80A, 1'b1, 1'b0, 1'b0, 1, 1'b0, 12'h000, 12'h007};
    tbl[12] = '{12'h80B, 1'b1, 1'b0, 1'b1, 2, 1'b0, 12'h004, 12'h00B};
    tbl[13] = '{12'h000, 1'b0, 1'b0, 1'b0, 2, 1'b0, 12'h004, 12'h00B};

    #2;
    apply_reset("t1 reset");

    // Idle after reset: everything stays at its reset value.
    repeat (20) step(12'h000, 1'b0, 1'b0, "t1 idle");

    // First frame and first hop.
    for (int j = 0; j < 14; j++) begin
      step(tbl[j].s, tbl[j].v, tbl[j].f, "t23 model");
      chk($sformatf("t23 row%0d frame_valid", j), 32'(if_a.frame_valid), 32'(tbl[j].fv));
      chk($sformatf("t23 row%0d frame_cnt", j), 32'(if_a.frame_cnt), 32'(tbl[j].cnt));
      chk($sformatf("t23 row%0d filling", j), 32'(if_a.filling), 32'(tbl[j].fill));
      chk($sformatf("t23 row%0d x_0", j), 32'(if_a.x_0), 32'(tbl[j].x0));
      chk($sformatf("t23 row%0d x_7", j), 32'(if_a.x_7), 32'(tbl[j].x7));
    end

    // Same frame again after a flush, with random gaps between samples.
    step(12'h000, 1'b0, 1'b1, "t4 flush");
    p0 = pulses_a;
    for (int j = 0; j < 8; j++) begin
      repeat ($urandom_range(5, 0)) step(12'h000, 1'b0, 1'b0, "t4 gap");
      step(12'(12'h800 + j), 1'b1, 1'b0, "t4 sample");
    end
    chk("t4 pulse count", 32'(pulses_a - p0), 32'd1);
    chk("t4 frame_valid", 32'(if_a.frame_valid), 32'd1);
    chk("t4 x_0", 32'(if_a.x_0), 32'h000);
    chk("t4 x_7", 32'(if_a.x_7), 32'h007);
    chk("t4 frame_cnt", 32'(if_a.frame_cnt), 32'd3);

    // Flush with a valid sample after 5 samples of FILL.
    step(12'h000, 1'b0, 1'b1, "t5 flush");
    for (int j = 0; j < 5; j++) step(12'(12'h100 + j), 1'b1, 1'b0, "t5 pre");
    step(12'h555, 1'b1, 1'b1, "t5 flush+valid");
    chk("t5 dropped frame_valid", 32'(if_a.frame_valid), 32'd0);
    chk("t5 held x_7", 32'(if_a.x_7), 32'h007);
    chk("t5 filling", 32'(if_a.filling), 32'd1);
    p0 = pulses_a;
    for (int j = 0; j < 8; j++) step(12'(12'h900 + j), 1'b1, 1'b0, "t5 refill");
    chk("t5 pulse count", 32'(pulses_a - p0), 32'd1);
    chk("t5 x_0", 32'(if_a.x_0), 32'h100);
    chk("t5 x_7", 32'(if_a.x_7), 32'h107);
    chk("t5 frame_cnt", 32'(if_a.frame_cnt), 32'd4);

    // HOP=1, 4-bit counter: 40 samples give 33 frames, count wraps to 1.
    apply_reset("t6 reset");
    p0 = pulses_b;
    for (int j = 0; j < 40; j++) begin
      smp = (j == 20) ? 12'h000 : (j == 21) ? 12'hFFF : 12'($urandom);
      step(smp, 1'b1, 1'b0, "t6 stream");
      if (j == 20) chk("t6 code 0x000", 32'(if_b.x_7), 32'h800);
      if (j == 21) chk("t6 code 0xFFF", 32'(if_b.x_7), 32'h7FF);
    end
    chk("t6 pulse count", 32'(pulses_b - p0), 32'd33);
    chk("t6 frame_cnt wrap", 32'(if_b.frame_cnt), 32'd1);
    for (int j = 0; j < 3; j++) step(12'($urandom), 1'b1, 1'b0, "t6 more");
    apply_reset("t6 midstream reset");

    // Random traffic against the model.
    for (int j = 0; j < 400; j++) begin
      r = $urandom_range(99, 0);
      step(12'($urandom), (r < 65) || (r >= 97 && r[0]), (r >= 97), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
